// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA processing element: command headers,
// op codes, CFG_OP field positions and the output-register state type.
package cgra_pkg;

    localparam logic [1:0] HDR_CFG_W  = 2'b00;
    localparam logic [1:0] HDR_CFG_OP = 2'b01;
    localparam logic [1:0] HDR_OPND   = 2'b10;
    localparam logic [1:0] HDR_FLUSH  = 2'b11;

    typedef enum logic [2:0] {
        OP_ADD3 = 3'b000,
        OP_AND3 = 3'b001,
        OP_MAC  = 3'b010,
        OP_MAX3 = 3'b011,
        OP_SUB  = 3'b100
    } op_e;

    localparam int CFG_OP_LSB      = 0;
    localparam int CFG_FWD_EN_BIT  = 3;
    localparam int CFG_FWD_DIR_BIT = 4;
    localparam int CFG_WSEL_LSB    = 5;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/cgra_pe_tile_if.sv
// Switch-side command/result channel of the PE tile.
// master = switch, slave = tile.
interface cgra_pe_tile_if #(
    parameter int DATA_W = 8
);
    logic              sw_in_valid;
    logic [DATA_W+1:0] sw_in_data;
    logic              sw_in_ready;
    logic              sw_out_valid;
    logic [DATA_W-1:0] sw_out_data;
    logic              sw_out_ready;

    modport master (
        output sw_in_valid, sw_in_data, sw_out_ready,
        input  sw_in_ready, sw_out_valid, sw_out_data
    );

    modport slave (
        input  sw_in_valid, sw_in_data, sw_out_ready,
        output sw_in_ready, sw_out_valid, sw_out_data
    );
endinterface

// File: rtl/cgra_pe_alu.sv
// Combinational datapath for the non-MAC ops; results saturate to all ones
// (or floor at zero for SUB) when SAT=1, otherwise wrap to DATA_W bits.
module cgra_pe_alu
    import cgra_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 4,
    parameter int SAT      = 1
) (
    input  op_e                 op,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [DATA_W-1:0]   payload,
    input  logic [DATA_W-1:0]   e_data,
    input  logic [DATA_W-1:0]   w_data,
    output logic [DATA_W-1:0]   result
);
    localparam int SUM_W = DATA_W + 2;

    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] max_v;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W:0]   diff;

    // Full-precision intermediate values, then op select and clamp.
    always_comb begin
        w_ext  = DATA_W'(weight);
        sum    = SUM_W'(w_ext) + SUM_W'(e_data) + SUM_W'(w_data);
        diff   = {1'b0, payload} - {1'b0, w_ext};
        max_v  = (payload > e_data) ? payload : e_data;
        if (w_data > max_v) max_v = w_data;
        result = '0;
        case (op)
            OP_AND3: result = w_ext & e_data & w_data;
            OP_MAX3: result = max_v;
            OP_SUB:  result = (SAT != 0 && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
            default: result = (SAT != 0 && sum[SUM_W-1:DATA_W] != '0) ? '1 : sum[DATA_W-1:0];
        endcase
    end
endmodule

// File: rtl/cgra_pe_tile.sv
// CGRA processing element: weight/op configuration, MAC accumulator,
// one-deep result register toward the switch and neighbour forwarding.
module cgra_pe_tile
    import cgra_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 4,
    parameter int N_W      = 4,
    parameter int ACC_W    = 16,
    parameter int SAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    cgra_pe_tile_if.slave     sw,
    input  logic              east_in_valid,
    input  logic [DATA_W-1:0] east_in_data,
    input  logic              west_in_valid,
    input  logic [DATA_W-1:0] west_in_data,
    output logic              east_out_valid,
    output logic [DATA_W-1:0] east_out_data,
    output logic              west_out_valid,
    output logic [DATA_W-1:0] west_out_data,
    output logic              acc_ovf
);
    localparam int WS_W   = $clog2(N_W);
    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic [1:0]          hdr;
    logic [DATA_W-1:0]   payload;
    logic                accept;
    logic [WEIGHT_W-1:0] weights [N_W];
    op_e                 op_q;
    logic                fwd_en_q, fwd_dir_q;
    logic [WS_W-1:0]     wsel_q;
    logic [ACC_W-1:0]    acc_q;
    logic                acc_ovf_q;
    out_state_e          state_q, state_d;
    logic [DATA_W-1:0]   out_data_q;
    logic                opnd_compute, opnd_fwd, new_result;
    logic [WEIGHT_W-1:0] w_cur;
    logic [DATA_W-1:0]   e_opnd, w_opnd, alu_result, flush_result;
    logic [PROD_W-1:0]   product;
    logic [ACC_W:0]      mac_sum;

    assign hdr            = sw.sw_in_data[DATA_W+1:DATA_W];
    assign payload        = sw.sw_in_data[DATA_W-1:0];
    assign sw.sw_in_ready = (state_q == OUT_EMPTY) || sw.sw_out_ready;
    assign accept         = sw.sw_in_valid && sw.sw_in_ready;
    assign sw.sw_out_valid = (state_q == OUT_FULL);
    assign sw.sw_out_data  = out_data_q;
    assign acc_ovf        = acc_ovf_q;
    assign w_cur          = weights[wsel_q];

    // Decode the accepted command and prepare neighbour operands, MAC sum and flush value.
    always_comb begin
        opnd_fwd     = accept && hdr == HDR_OPND && fwd_en_q;
        opnd_compute = accept && hdr == HDR_OPND && !fwd_en_q;
        new_result   = (opnd_compute && op_q != OP_MAC) || (accept && hdr == HDR_FLUSH);
        e_opnd       = east_in_data;
        w_opnd       = west_in_data;
        // A silent neighbour is neutral for the op: zero, or all ones for AND3.
        if (!east_in_valid) e_opnd = (op_q == OP_AND3) ? '1 : '0;
        if (!west_in_valid) w_opnd = (op_q == OP_AND3) ? '1 : '0;
        product      = PROD_W'(payload) * PROD_W'(w_cur);
        mac_sum      = {1'b0, acc_q} + (ACC_W+1)'(product);
        flush_result = (SAT != 0 && acc_q[ACC_W-1:DATA_W] != '0) ? '1 : acc_q[DATA_W-1:0];
    end

    cgra_pe_alu #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .SAT      (SAT)
    ) u_alu (
        .op      (op_q),
        .weight  (w_cur),
        .payload (payload),
        .e_data  (e_opnd),
        .w_data  (w_opnd),
        .result  (alu_result)
    );

    // Configuration registers: weight slots, op, forward enable/direction, weight select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_W; i++) weights[i] <= '0;
            op_q      <= OP_ADD3;
            fwd_en_q  <= 1'b0;
            fwd_dir_q <= 1'b0;
            wsel_q    <= '0;
        end else if (accept && hdr == HDR_CFG_W) begin
            weights[payload[WEIGHT_W +: WS_W]] <= payload[WEIGHT_W-1:0];
        end else if (accept && hdr == HDR_CFG_OP) begin
            op_q      <= op_e'(payload[CFG_OP_LSB +: 3]);
            fwd_en_q  <= payload[CFG_FWD_EN_BIT];
            fwd_dir_q <= payload[CFG_FWD_DIR_BIT];
            wsel_q    <= payload[CFG_WSEL_LSB +: WS_W];
        end
    end

    // Accumulator with sticky wrap flag; FLUSH clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else if (accept && hdr == HDR_FLUSH) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else if (opnd_compute && op_q == OP_MAC) begin
            acc_q <= mac_sum[ACC_W-1:0];
            if (mac_sum[ACC_W]) acc_ovf_q <= 1'b1;
        end
    end

    // One-cycle forward pulses toward the selected neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            east_out_valid <= 1'b0;
            west_out_valid <= 1'b0;
            east_out_data  <= '0;
            west_out_data  <= '0;
        end else begin
            east_out_valid <= opnd_fwd && !fwd_dir_q;
            west_out_valid <= opnd_fwd && fwd_dir_q;
            if (opnd_fwd && !fwd_dir_q) east_out_data <= payload;
            if (opnd_fwd && fwd_dir_q)  west_out_data <= payload;
        end
    end

    // Result register; only loads on accept, which implies it is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_data_q <= '0;
        else if (new_result) out_data_q <= (hdr == HDR_FLUSH) ? flush_result : alu_result;
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OUT_EMPTY;
        else        state_q <= state_d;
    end

    // Output FSM next state: a new result wins over draining.
    always_comb begin
        state_d = state_q;
        if (new_result) state_d = OUT_FULL;
        else if (state_q == OUT_FULL && sw.sw_out_ready) state_d = OUT_EMPTY;
    end
endmodule

// File: tb/tb_cgra_pe_tile.sv
// Bench for cgra_pe_tile: a saturating and a wrapping instance share the same
// stimulus; a reference model pushes expected results into scoreboards.
module tb_cgra_pe_tile;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cgra_pe_tile_if #(.DATA_W(DW)) sw1 ();
    cgra_pe_tile_if #(.DATA_W(DW)) sw0 ();

    logic          east_in_valid, west_in_valid;
    logic [DW-1:0] east_in_data, west_in_data;
    logic          e1v, w1v, ovf1, e0v, w0v, ovf0;
    logic [DW-1:0] e1d, w1d, e0d, w0d;

    assign sw0.sw_in_valid  = sw1.sw_in_valid;
    assign sw0.sw_in_data   = sw1.sw_in_data;
    assign sw0.sw_out_ready = sw1.sw_out_ready;

    cgra_pe_tile #(.DATA_W(DW), .WEIGHT_W(4), .N_W(4), .ACC_W(16), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw1.slave),
        .east_in_valid(east_in_valid), .east_in_data(east_in_data),
        .west_in_valid(west_in_valid), .west_in_data(west_in_data),
        .east_out_valid(e1v), .east_out_data(e1d),
        .west_out_valid(w1v), .west_out_data(w1d), .acc_ovf(ovf1)
    );

    cgra_pe_tile #(.DATA_W(DW), .WEIGHT_W(4), .N_W(4), .ACC_W(16), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sw(sw0.slave),
        .east_in_valid(east_in_valid), .east_in_data(east_in_data),
        .west_in_valid(west_in_valid), .west_in_data(west_in_data),
        .east_out_valid(e0v), .east_out_data(e0d),
        .west_out_valid(w0v), .west_out_data(w0d), .acc_ovf(ovf0)
    );

    int n_chk = 0;
    int n_err = 0;

    int q_sat[$];
    int q_wrap[$];
    int fwd_q[$];

    int mw[4];
    int mop, mwsel, macc;
    bit mfwd, mdir, movf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        mop = 0; mwsel = 0; macc = 0;
        mfwd = 0; mdir = 0; movf = 0;
        q_sat.delete(); q_wrap.delete(); fwd_q.delete();
    endtask

    // Reference model update and scoreboard push for one command.
    task automatic model_cmd(input logic [1:0] h, input int p);
        int w, e, wn, s;
        case (h)
            2'b00: mw[(p >> 4) & 3] = p & 15;
            2'b01: begin
                mop = p & 7; mfwd = p[3]; mdir = p[4]; mwsel = (p >> 5) & 3;
            end
            2'b10: begin
                if (mfwd) fwd_q.push_back((mdir ? 512 : 256) + (p & 255));
                else begin
                    w  = mw[mwsel];
                    e  = east_in_valid ? int'(east_in_data) : (mop == 1 ? 255 : 0);
                    wn = west_in_valid ? int'(west_in_data) : (mop == 1 ? 255 : 0);
                    case (mop)
                        2: begin
                            macc = macc + p * w;
                            if (macc > 65535) begin macc = macc - 65536; movf = 1; end
                        end
                        1: begin q_sat.push_back(w & e & wn); q_wrap.push_back(w & e & wn); end
                        3: begin
                            s = p;
                            if (e > s) s = e;
                            if (wn > s) s = wn;
                            q_sat.push_back(s); q_wrap.push_back(s);
                        end
                        4: begin
                            s = p - w;
                            q_sat.push_back(s < 0 ? 0 : s); q_wrap.push_back(s & 255);
                        end
                        default: begin
                            s = w + e + wn;
                            q_sat.push_back(s > 255 ? 255 : s); q_wrap.push_back(s & 255);
                        end
                    endcase
                end
            end
            default: begin
                q_sat.push_back(macc > 255 ? 255 : macc); q_wrap.push_back(macc & 255);
                macc = 0; movf = 0;
            end
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] h, input int p);
        int unsigned n;
        logic [7:0] pb;
        pb = p[7:0];
        model_cmd(h, p);
        sw1.sw_in_valid = 1'b1;
        sw1.sw_in_data  = {h, pb};
        #1;
        n = 0;
        while (!sw1.sw_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!sw1.sw_in_ready) begin
            check("in_ready_timeout", sw1.sw_in_ready, 1);
            sw1.sw_in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            sw1.sw_in_valid = 1'b0;
        end
    endtask

    // Scoreboard side: compare every consumed result and every forward pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sw1.sw_out_valid && sw1.sw_out_ready) begin
                if (q_sat.size() == 0) check("sat_q_nonempty", q_sat.size(), 1);
                else check("sat_result", sw1.sw_out_data, q_sat.pop_front());
            end
            if (sw0.sw_out_valid && sw0.sw_out_ready) begin
                if (q_wrap.size() == 0) check("wrap_q_nonempty", q_wrap.size(), 1);
                else check("wrap_result", sw0.sw_out_data, q_wrap.pop_front());
            end
            if (e1v || w1v || e0v || w0v) begin
                if (fwd_q.size() == 0) check("fwd_q_nonempty", fwd_q.size(), 1);
                else begin
                    int f;
                    f = fwd_q.pop_front();
                    check("fwd_sat", {w1v, e1v, (w1v ? w1d : e1d)}, f);
                    check("fwd_wrap", {w0v, e0v, (w0v ? w0d : e0d)}, f);
                end
            end
        end
    end

    initial begin
        sw1.sw_in_valid  = 1'b0;
        sw1.sw_in_data   = '0;
        sw1.sw_out_ready = 1'b1;
        east_in_valid = 1'b0; east_in_data = '0;
        west_in_valid = 1'b0; west_in_data = '0;
        model_reset();
        #22 rst_n = 1'b1;
        #1;
        check("rst_in_ready", sw1.sw_in_ready, 1);
        check("rst_out_valid", {sw1.sw_out_valid, sw0.sw_out_valid}, 0);
        check("rst_out_data", sw1.sw_out_data, 0);
        check("rst_fwd", {e1v, w1v, e1d, w1d}, 0);
        check("rst_ovf", {ovf1, ovf0}, 0);
        @(posedge clk); #1;

        // ADD3 with weight slot 1, both neighbours valid
        send(2'b00, 'h15);
        send(2'b01, 'h20);
        east_in_valid = 1'b1; east_in_data = 8'd10;
        west_in_valid = 1'b1; west_in_data = 8'd20;
        send(2'b10, 0);
        check("latency_valid", sw1.sw_out_valid, 1);

        // ADD3 overflow: saturate vs wrap
        send(2'b00, 'h1F);
        east_in_data = 8'd200; west_in_data = 8'd100;
        send(2'b10, 0);

        // AND3 with silent west neighbour
        west_in_valid = 1'b0;
        send(2'b01, 'h21);
        send(2'b10, 0);

        // MAX3, then with silent east neighbour
        west_in_valid = 1'b1;
        send(2'b01, 'h23);
        send(2'b10, 'h90);
        east_in_valid = 1'b0;
        send(2'b10, 'h90);

        // SUB below and above the weight; unnamed op code falls back to ADD3
        send(2'b00, 'h29);
        send(2'b01, 'h44);
        send(2'b10, 5);
        send(2'b10, 20);
        send(2'b01, 'h47);
        send(2'b10, 0);

        // Forwarding west, then east
        send(2'b01, 'h18);
        send(2'b10, 'h2A);
        check("fwd_west_pulse", w1v, 1);
        check("fwd_no_sw_out", sw1.sw_out_valid, 0);
        @(posedge clk); #1;
        check("fwd_pulse_end", w1v, 0);
        send(2'b01, 'h08);
        send(2'b10, 'h33);
        check("fwd_east_pulse", e1v, 1);

        // MAC 10,20,30 with w=3, then two flushes
        send(2'b00, 'h03);
        send(2'b01, 'h02);
        send(2'b10, 10);
        send(2'b10, 20);
        send(2'b10, 30);
        send(2'b11, 0);
        send(2'b11, 0);

        // MAC until the accumulator wraps
        send(2'b00, 'h3F);
        send(2'b01, 'h62);
        for (int i = 0; i < 18; i++) send(2'b10, 255);
        check("acc_ovf_set", ovf1, movf);
        check("acc_ovf_set_wrap", ovf0, movf);
        send(2'b11, 0);
        check("acc_ovf_clear", ovf1, movf);

        // Backpressure hold, then release together with a new operand
        east_in_valid = 1'b1; east_in_data = 8'd10;
        west_in_valid = 1'b1; west_in_data = 8'd20;
        send(2'b01, 'h20);
        sw1.sw_out_ready = 1'b0;
        send(2'b10, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", sw1.sw_in_ready, 0);
            check("stall_data", sw1.sw_out_data, q_sat[0]);
        end
        sw1.sw_out_ready = 1'b1;
        east_in_data = 8'd1;
        send(2'b10, 0);
        check("no_gap_valid", sw1.sw_out_valid, 1);

        // Asynchronous reset while a result is pending
        @(posedge clk); #1;
        sw1.sw_out_ready = 1'b0;
        send(2'b10, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {sw1.sw_out_valid, sw0.sw_out_valid}, 0);
        check("arst_out_data", sw1.sw_out_data, 0);
        check("arst_in_ready", sw1.sw_in_ready, 1);
        model_reset();
        sw1.sw_out_ready = 1'b1;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        east_in_data = 8'd10;
        send(2'b10, 0);

        // Asynchronous reset during a forward pulse
        send(2'b01, 'h18);
        send(2'b10, 'h55);
        check("mid_fwd_pulse", w1v, 1);
        rst_n = 1'b0;
        #1;
        check("arst_fwd", {w1v, w1d, w0v, w0d}, 0);
        model_reset();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(2'b10, 'h07);
        check("cfg_cleared_sw_out", sw1.sw_out_valid, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sat_q_drained", q_sat.size(), 0);
        check("wrap_q_drained", q_wrap.size(), 0);
        check("fwd_q_drained", fwd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
